// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - handshake bundle between the burst reader, the async FIFO read port and downstream
//
// Purpose: groups the three handshakes the burst reader takes part in.
//   FIFO read side : r_empty, rdata (FIFO -> reader), r_en (reader -> FIFO)
//   request side   : req_valid, req_len (-> reader), req_ready (reader ->)
//   output stream  : out_valid, out_data, out_last (reader ->), out_ready (-> reader)
// Modports:
//   slave  - the burst reader itself
//   master - the environment (FIFO, requester and downstream sink)

interface fifo_burst_reader_if #(
  parameter int MEMORY_WIDTH = 8,
  parameter int LEN_WIDTH    = 8
);

  logic                    r_empty;
  logic [MEMORY_WIDTH-1:0] rdata;
  logic                    r_en;

  logic                    req_valid;
  logic [LEN_WIDTH-1:0]    req_len;
  logic                    req_ready;

  logic                    out_valid;
  logic                    out_ready;
  logic [MEMORY_WIDTH-1:0] out_data;
  logic                    out_last;

  modport slave (
    input  r_empty, rdata, req_valid, req_len, out_ready,
    output r_en, req_ready, out_valid, out_data, out_last
  );

  modport master (
    output r_empty, rdata, req_valid, req_len, out_ready,
    input  r_en, req_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains bursts of words from the async FIFO read port onto a valid/ready stream
//
// Purpose: accepts a burst request (req_len words), pops that many words from
// the FIFO as they become available and forwards them through a 2-entry
// registered output buffer, tagging the final word with out_last. burst_done
// pulses one cycle after the final word is accepted, or one cycle after a
// zero-length request.
// Ports:
//   r_clk      - read-domain clock, all state on its rising edge
//   rrst       - synchronous active-high reset
//   bus        - fifo_burst_reader_if.slave (FIFO read port, request, output stream)
//   burst_done - one-cycle end-of-burst pulse
//   words_read - free-running count of popped words, wraps

module fifo_burst_reader #(
  parameter int MEMORY_WIDTH = 8,
  parameter int LEN_WIDTH    = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 r_clk,
  input  logic                 rrst,
  fifo_burst_reader_if.slave   bus,
  output logic                 burst_done,
  output logic [CNT_WIDTH-1:0] words_read
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    pop_rem_q, pop_rem_d;
  logic [1:0]              occ_q, occ_d;
  logic [MEMORY_WIDTH-1:0] head_data_q, head_data_d;
  logic                    head_last_q, head_last_d;
  logic [MEMORY_WIDTH-1:0] tail_data_q, tail_data_d;
  logic                    tail_last_q, tail_last_d;
  logic                    done_q, done_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic pop;
  logic accept;
  logic push_last;
  logic out_valid;

  always_comb begin
    state_d     = state_q;
    pop_rem_d   = pop_rem_q;
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    done_d      = 1'b0;

    out_valid = (occ_q != 2'd0);
    accept    = out_valid && bus.out_ready;
    // A full buffer can take a new word only when the head leaves in the
    // same cycle. Popping is suppressed during reset so words that were
    // never buffered stay in the FIFO.
    pop = (state_q == ACTIVE) && (pop_rem_q != '0) && !bus.r_empty &&
          ((occ_q < 2'd2) || ((occ_q == 2'd2) && bus.out_ready)) && !rrst;
    push_last = (pop_rem_q == LEN_WIDTH'(1));

    cnt_d = cnt_q + CNT_WIDTH'(pop);

    // Output buffer: head is the registered output, tail the second entry.
    case (occ_q)
      2'd0: begin
        if (pop) begin
          head_data_d = bus.rdata;
          head_last_d = push_last;
          occ_d       = 2'd1;
        end
      end
      2'd1: begin
        if (pop && accept) begin
          head_data_d = bus.rdata;
          head_last_d = push_last;
        end else if (pop) begin
          tail_data_d = bus.rdata;
          tail_last_d = push_last;
          occ_d       = 2'd2;
        end else if (accept) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        // A pop with occ=2 implies accept, so push-only cannot happen here.
        if (accept) begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          if (pop) begin
            tail_data_d = bus.rdata;
            tail_last_d = push_last;
          end else begin
            occ_d = 2'd1;
          end
        end
      end
    endcase

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_len == '0) begin
            done_d = 1'b1;
          end else begin
            pop_rem_d = bus.req_len;
            state_d   = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (pop) begin
          pop_rem_d = pop_rem_q - LEN_WIDTH'(1);
          if (push_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Everything still buffered belongs to this burst, so an empty
        // buffer after this edge means the last word has been taken.
        if (occ_d == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (rrst) begin
      state_q     <= IDLE;
      pop_rem_q   <= '0;
      occ_q       <= 2'd0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pop_rem_q   <= pop_rem_d;
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.r_en      = pop;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_data_q;
  assign bus.out_last  = out_valid && head_last_q;
  assign burst_done    = done_q;
  assign words_read    = cnt_q;

  a_no_pop_when_empty: assert property (@(posedge r_clk) disable iff (rrst)
    !(bus.r_en && bus.r_empty));

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader

module tb_fifo_burst_reader;

  localparam int MW = 8;
  localparam int LW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rrst;
  logic          burst_done;
  logic [CW-1:0] words_read;

  fifo_burst_reader_if #(.MEMORY_WIDTH(MW), .LEN_WIDTH(LW)) bus ();

  fifo_burst_reader #(.MEMORY_WIDTH(MW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .r_clk      (clk),
    .rrst       (rrst),
    .bus        (bus),
    .burst_done (burst_done),
    .words_read (words_read)
  );

  always #5 clk = ~clk;

  // FIFO model: array with read/write pointers, head word combinational.
  logic [7:0] mem [0:127];
  logic [6:0] wr_ptr = '0;
  logic [6:0] rd_ptr = '0;

  assign bus.r_empty = (wr_ptr == rd_ptr);
  assign bus.rdata   = mem[rd_ptr];

  // Stream / event recorder.
  int         cyc_cnt  = 0;
  int         pop_cnt  = 0;
  int         acc_cnt  = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic [7:0] acc_data [0:127];
  logic       acc_last [0:127];
  int         acc_cyc  [0:127];

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (bus.r_en) begin
      rd_ptr  <= rd_ptr + 7'd1;
      pop_cnt <= pop_cnt + 1;
    end
    if (bus.out_valid && bus.out_ready && !rrst) begin
      acc_data[7'(acc_cnt)] <= bus.out_data;
      acc_last[7'(acc_cnt)] <= bus.out_last;
      acc_cyc[7'(acc_cnt)]  <= cyc_cnt;
      acc_cnt               <= acc_cnt + 1;
    end
    if (burst_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc_cnt;
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 7'd1;
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int i = 0; i < 100 && done_cnt == d0; i++) tick();
    chk(tag, 32'(done_cnt - d0), 1);
  endtask

  task automatic run_burst(input logic [7:0] len, input string tag);
    int d0;
    for (int i = 0; i < 50 && !bus.req_ready; i++) tick();
    d0            = done_cnt;
    bus.req_valid = 1'b1;
    bus.req_len   = len;
    tick();
    bus.req_valid = 1'b0;
    wait_done(d0, tag);
  endtask

  int p0, a0, d0;

  initial begin
    rrst          = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_len   = '0;
    bus.out_ready = 1'b1;

    // Reset values.
    tick();
    tick();
    chk("rst_r_en",       32'(bus.r_en), 0);
    chk("rst_req_ready",  32'(bus.req_ready), 1);
    chk("rst_out_valid",  32'(bus.out_valid), 0);
    chk("rst_out_last",   32'(bus.out_last), 0);
    chk("rst_burst_done", 32'(burst_done), 0);
    chk("rst_words_read", 32'(words_read), 0);
    chk("rst_out_data",   32'(bus.out_data), 0);
    rrst = 1'b0;
    tick();

    // Burst of 3 with the words already waiting.
    p0 = pop_cnt;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    bus.req_valid = 1'b1;
    bus.req_len   = 8'd3;
    tick();
    bus.req_valid = 1'b0;
    chk("b3_c1_r_en",      32'(bus.r_en), 1);
    chk("b3_c1_out_valid", 32'(bus.out_valid), 0);
    tick();
    chk("b3_c2_r_en",      32'(bus.r_en), 1);
    chk("b3_c2_out_valid", 32'(bus.out_valid), 1);
    chk("b3_c2_data",      32'(bus.out_data), 'h11);
    chk("b3_c2_last",      32'(bus.out_last), 0);
    tick();
    chk("b3_c3_r_en",      32'(bus.r_en), 1);
    chk("b3_c3_data",      32'(bus.out_data), 'h22);
    chk("b3_c3_last",      32'(bus.out_last), 0);
    tick();
    chk("b3_c4_r_en",      32'(bus.r_en), 0);
    chk("b3_c4_data",      32'(bus.out_data), 'h33);
    chk("b3_c4_last",      32'(bus.out_last), 1);
    chk("b3_c4_done",      32'(burst_done), 0);
    tick();
    chk("b3_c5_done",      32'(burst_done), 1);
    chk("b3_c5_out_valid", 32'(bus.out_valid), 0);
    chk("b3_c5_req_ready", 32'(bus.req_ready), 1);
    tick();
    chk("b3_c6_done",      32'(burst_done), 0);
    chk("b3_words_read",   32'(words_read), 3);
    chk("b3_pops",         32'(pop_cnt - p0), 3);

    // Burst of 4 with the FIFO running dry halfway.
    p0 = pop_cnt; a0 = acc_cnt; d0 = done_cnt;
    push_word(8'hA1); push_word(8'hA2);
    bus.req_valid = 1'b1;
    bus.req_len   = 8'd4;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    chk("b4_empty_r_empty", 32'(bus.r_empty), 1);
    chk("b4_empty_r_en",    32'(bus.r_en), 0);
    tick();
    tick();
    chk("b4_stall_r_en",    32'(bus.r_en), 0);
    chk("b4_stall_pops",    32'(pop_cnt - p0), 2);
    chk("b4_stall_no_done", 32'(done_cnt - d0), 0);
    push_word(8'hA3); push_word(8'hA4);
    wait_done(d0, "b4_done_timeout");
    chk("b4_acc_count", 32'(acc_cnt - a0), 4);
    for (int i = 0; i < 4; i++) begin
      chk("b4_data", 32'(acc_data[7'(a0 + i)]), 32'('hA1 + i));
      chk("b4_last", 32'(acc_last[7'(a0 + i)]), (i == 3) ? 1 : 0);
    end
    chk("b4_done_after_last", done_cyc, acc_cyc[7'(a0 + 3)] + 1);
    chk("b4_words_read", 32'(words_read), 7);

    // Burst of 5 with downstream stalled for 10 cycles.
    p0 = pop_cnt; a0 = acc_cnt; d0 = done_cnt;
    for (int i = 0; i < 5; i++) push_word(8'(8'hB1 + i));
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_len   = 8'd5;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    chk("b5_stall_data_early",  32'(bus.out_data), 'hB1);
    for (int i = 0; i < 7; i++) tick();
    chk("b5_stall_pops",        32'(pop_cnt - p0), 2);
    chk("b5_stall_r_en",        32'(bus.r_en), 0);
    chk("b5_stall_valid",       32'(bus.out_valid), 1);
    chk("b5_stall_data_late",   32'(bus.out_data), 'hB1);
    bus.out_ready = 1'b1;
    #1;
    chk("b5_resume_r_en0",      32'(bus.r_en), 1);
    tick();
    chk("b5_resume_r_en1",      32'(bus.r_en), 1);
    chk("b5_resume_data1",      32'(bus.out_data), 'hB2);
    tick();
    chk("b5_resume_r_en2",      32'(bus.r_en), 1);
    tick();
    chk("b5_resume_r_en3",      32'(bus.r_en), 0);
    chk("b5_pops",              32'(pop_cnt - p0), 5);
    wait_done(d0, "b5_done_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("b5_data", 32'(acc_data[7'(a0 + i)]), 32'('hB1 + i));
      chk("b5_last", 32'(acc_last[7'(a0 + i)]), (i == 4) ? 1 : 0);
    end
    chk("b5_words_read", 32'(words_read), 12);

    // Zero-length request.
    p0 = pop_cnt; d0 = done_cnt;
    tick();
    bus.req_valid = 1'b1;
    bus.req_len   = 8'd0;
    #1;
    chk("z_req_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
    chk("z_done",      32'(burst_done), 1);
    chk("z_r_en",      32'(bus.r_en), 0);
    chk("z_out_valid", 32'(bus.out_valid), 0);
    chk("z_req_ready_after", 32'(bus.req_ready), 1);
    tick();
    chk("z_done_clear", 32'(burst_done), 0);
    chk("z_pops",       32'(pop_cnt - p0), 0);

    // Reset after two of six words popped.
    p0 = pop_cnt; d0 = done_cnt;
    for (int i = 0; i < 6; i++) push_word(8'(8'hC1 + i));
    bus.req_valid = 1'b1;
    bus.req_len   = 8'd6;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    rrst = 1'b1;
    #1;
    chk("mr_r_en_in_reset", 32'(bus.r_en), 0);
    tick();
    rrst = 1'b0;
    chk("mr_r_en",       32'(bus.r_en), 0);
    chk("mr_req_ready",  32'(bus.req_ready), 1);
    chk("mr_out_valid",  32'(bus.out_valid), 0);
    chk("mr_out_last",   32'(bus.out_last), 0);
    chk("mr_burst_done", 32'(burst_done), 0);
    chk("mr_words_read", 32'(words_read), 0);
    chk("mr_out_data",   32'(bus.out_data), 0);
    chk("mr_pops",       32'(pop_cnt - p0), 2);
    chk("mr_fifo_left",  32'(wr_ptr - rd_ptr), 4);
    chk("mr_fifo_head",  32'(bus.rdata), 'hC3);
    for (int i = 0; i < 5; i++) tick();
    chk("mr_no_done",    32'(done_cnt - d0), 0);

    // Counter wrap: 4 leftover + 7 + 7 = 18 words on a 4-bit counter.
    a0 = acc_cnt; d0 = done_cnt;
    run_burst(8'd4, "w1_done_timeout");
    chk("w1_first", 32'(acc_data[7'(a0)]), 'hC3);
    chk("w1_final", 32'(acc_data[7'(a0 + 3)]), 'hC6);
    for (int i = 0; i < 14; i++) push_word(8'(8'hD0 + i));
    run_burst(8'd7, "w2_done_timeout");
    run_burst(8'd7, "w3_done_timeout");
    chk("w_done_count",  32'(done_cnt - d0), 3);
    chk("w_fifo_empty",  32'(bus.r_empty), 1);
    chk("w_words_read",  32'(words_read), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the team's asynchronous FIFO. Sits in the r_clk domain and drives r_en from r_empty/rdata.
- Drains a requested number of words (a burst) and presents them downstream on a valid/ready stream, with an end-of-burst marker.
- A 2-entry output buffer decouples downstream backpressure from FIFO pops.

Parameters:
- MEMORY_WIDTH, 8, FIFO word width; width of rdata and out_data.
- LEN_WIDTH, 8, width of the burst length field; maximum burst is 2^LEN_WIDTH-1 words.
- CNT_WIDTH, 16, width of the free-running popped-word counter.

Ports:
- r_clk  input  1  read-domain clock; all logic on its rising edge.
- rrst  input  1  synchronous active-high reset.
- r_empty  input  1  FIFO empty flag (read domain).
- rdata  input  MEMORY_WIDTH  FIFO head word, combinational; valid whenever r_empty=0.
- r_en  output  1  FIFO pop; the head word is consumed at the r_clk edge where r_en=1.
- req_valid  input  1  burst request valid.
- req_len  input  LEN_WIDTH  number of words to read.
- req_ready  output  1  request accepted when req_valid & req_ready.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept.
- out_data  output  MEMORY_WIDTH  buffered FIFO word.
- out_last  output  1  marks the final word of the burst; qualified by out_valid.
- burst_done  output  1  one-cycle pulse when the last word of a burst is accepted downstream, or for a zero-length request.
- words_read  output  CNT_WIDTH  total words popped since reset; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rrst=1 at an edge):
  - State goes to IDLE; buffer occupancy occ goes to 0; counters go to 0.
  - Outputs after reset: r_en=0, req_ready=1, out_valid=0, out_last=0, burst_done=0, words_read=0, out_data=0.
- Reset mid-burst:
  - The burst is abandoned and buffered words are discarded.
  - Words not yet popped stay in the FIFO.
  - No burst_done pulse is produced.
- State machine, IDLE -> ACTIVE -> DRAIN -> IDLE:
  - IDLE: req_ready=1. On req_valid with req_len != 0, latch pop_rem=req_len and go to ACTIVE.
  - IDLE, req_len=0: the request is accepted, burst_done pulses on the next cycle, and the block stays in IDLE.
  - ACTIVE: req_ready=0. When pop_rem reaches 0 after a pop, go to DRAIN.
  - DRAIN: wait until occ=0 with the final word accepted; burst_done=1 on the following cycle, then IDLE.
  - A new request may be accepted in the same cycle burst_done is high (back-to-back bursts, one IDLE cycle minimum).
- r_en (combinational) = ACTIVE & pop_rem!=0 & !r_empty & (occ<2 | (occ==2 & out_ready)).
  - r_en is never 1 while r_empty=1; this is a hard assertion.
- On a pop edge, rdata is written into the buffer tail, pop_rem decrements, and words_read increments.
  - Pop latency: word popped at edge k is visible on out_data with out_valid=1 after edge k (first cycle of k+1) if the buffer was empty.
- Output buffer:
  - 2-entry FIFO, registered outputs, first-word order preserved.
  - Simultaneous push and accept keeps occ unchanged.
  - Sustained throughput is 1 word/cycle when the FIFO is non-empty and out_ready=1.
- out_last is 1 exactly on the buffered word that was the burst's final pop (tag bit stored per entry).
- out_data and out_valid hold stable while out_valid=1 & out_ready=0.
- pop_rem width is LEN_WIDTH; there is no underflow because a pop requires pop_rem!=0.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33; req_len=3, out_ready=1 -> r_en high 3 consecutive cycles; out_data 0x11,0x22,0x33 on consecutive cycles; out_last only on 0x33; burst_done one pulse; words_read=3.
- req_len=4, FIFO holds 2 words, 2 more written 5 cycles later -> r_en drops while r_empty=1; stream resumes; out_last on the 4th word; burst_done only after it is accepted.
- req_len=5, out_ready=0 for 10 cycles then 1 -> exactly 2 pops during the stall (occ=2); out_data stable; remaining 3 pops resume at 1/cycle once out_ready=1.
- req_len=0 in IDLE -> no r_en, no out_valid; burst_done pulses once the next cycle.
- rrst asserted after 2 of 6 words popped -> next cycle all outputs at reset values; FIFO retains the 4 unpopped words; no burst_done.
- 2^CNT_WIDTH+2 words popped via repeated bursts (CNT_WIDTH=4 build) -> words_read wraps to 2.
